rca_result_checker: RTL and testbench
=====================================

Name: rca_result_checker

Overview:
- Synthesizable response checker; sits at the output end of the adder/subtractor test path, opposite the operand stimulus generator.
- Samples each operand/result vector presented by the ripple-carry adder under test, recomputes the expected {Cout,Sum}, and counts passes and fails.
- Latches the first failing vector and reports a pass/fail verdict once a programmed number of vectors has been checked.

Parameters:
- WIDTH, 2, operand and sum width in bits (legal range 1 to 16).
- NUM_VECTORS, 9, number of vectors per run; equals the 3x3 operand sweep.
- CNT_W, 8, width of the pass/fail counters; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new run.
- vld  in  1  vector-valid strobe from the stimulus side.
- A  in  WIDTH  operand A applied to the DUT.
- B  in  WIDTH  operand B applied to the DUT.
- Cin  in  1  carry-in applied to the DUT.
- Sum  in  WIDTH  DUT sum output.
- Cout  in  1  DUT carry-out.
- ready  out  1  high while the checker accepts vectors.
- pass_cnt  out  CNT_W  number of matching vectors.
- fail_cnt  out  CNT_W  number of mismatching vectors.
- first_fail  out  2*WIDTH+1  {A,B,Cin} of the first mismatch; zero if none.
- done  out  1  run complete; held until the next start.
- pass  out  1  valid when done=1; high iff fail_cnt==0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0, FSM forced to IDLE.
  - Takes effect immediately, including mid-run; partial counts are discarded.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: ready=0; vld ignored. start -> CHECK, and in the same edge clear counters, first_fail, done, pass and the internal vector index.
  - CHECK: ready=1. Each cycle with vld=1 is one vector (no backpressure; the source may assert vld on consecutive cycles).
  - DONE: ready=0, done=1; vld ignored. start -> CHECK with the same clear as from IDLE.
- Compare, per accepted vector:
  - expected = A + B + Cin, computed at WIDTH+1 bits with zero-extension.
  - Match iff {Cout,Sum} == expected.
  - Inputs are registered on the accepting edge; compare and counter update happen on the next edge (latency 1 cycle, pipelined at full rate).
- Counters:
  - Match -> pass_cnt+1; mismatch -> fail_cnt+1.
  - Counters saturate at all-ones and never wrap.
- first_fail: loaded only on the first mismatch of a run; later mismatches leave it unchanged.
- Vector index:
  - Increments on each accepted vector.
  - When the index reaches NUM_VECTORS, ready drops in the following cycle, so vld in that cycle is ignored.
  - The FSM enters DONE one cycle after the last compare retires.
  - done and pass assert together, with final counts already stable.
- start while in CHECK: restarts the run; the clear wins over any compare retiring that same cycle.
- vld together with start in IDLE/DONE: vld ignored; the first vector is accepted on the following cycle.
- Wrap-around: full-scale operands (e.g. A=B=2^WIDTH-1, Cin=1) produce expected with MSB set; Cout must equal that MSB.

Test Plan:
- Reset mid-run: assert rst_n=0 after 4 vectors -> all outputs 0 immediately; ready=0; after release the FSM sits in IDLE.
- Clean sweep, WIDTH=2, Cin=0, A and B each in {0,1,2}, 9 back-to-back vld cycles with correct results -> pass_cnt=9, fail_cnt=0, done=1, pass=1, first_fail=0.
- Injected error: vector A=2,B=1,Cin=0 driven with Sum=2'b10,Cout=0 (expected 3'b011); all others correct -> fail_cnt=1, pass_cnt=8, first_fail=5'b10_01_0, pass=0.
- Overflow/wrap: A=3,B=3,Cin=1 with Sum=3,Cout=1 -> counted as pass; the same vector with Cout=0 -> counted as fail.
- Gapped vld and extra vectors: 9 vectors with random idle gaps, then a 10th vld after the last -> exactly 9 counted, 10th ignored, done asserts 2 cycles after the 9th vld.
- Restart: start pulse in DONE, then 9 vectors with 2 errors -> counters cleared on start, final fail_cnt=2, first_fail holds the earlier of the two failing vectors.

Source files
------------

// File: rtl/rca_result_checker.sv
// Response checker for a ripple-carry adder under test: recomputes {Cout,Sum} for each
// presented vector, counts passes/fails, latches the first failure and reports a verdict.
module rca_result_checker #(
  parameter int WIDTH       = 2,
  parameter int NUM_VECTORS = 9,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               vld,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Cin,
  input  logic [WIDTH-1:0]   Sum,
  input  logic               Cout,
  output logic               ready,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [2*WIDTH:0]   first_fail,
  output logic               done,
  output logic               pass
);

  localparam int IDX_W = $clog2(NUM_VECTORS + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_VECTORS);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [2*WIDTH:0]   first_fail_q, first_fail_d;
  logic               vld_p0_q, vld_p0_d;
  logic [WIDTH-1:0]   a_p0_q, a_p0_d, b_p0_q, b_p0_d, sum_p0_q, sum_p0_d;
  logic               cin_p0_q, cin_p0_d, cout_p0_q, cout_p0_d;
  logic               accept;
  logic               match;

  function automatic logic [WIDTH:0] exp_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ready  = (state_q == CHECK) && (idx_q != IDX_END);
  // A start cycle is a clear cycle; any vld alongside it is dropped.
  assign accept = ready && vld && !start;
  assign match  = ({cout_p0_q, sum_p0_q} == exp_sum(a_p0_q, b_p0_q, cin_p0_q));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    vld_p0_d     = accept;
    a_p0_d       = accept ? A    : a_p0_q;
    b_p0_d       = accept ? B    : b_p0_q;
    cin_p0_d     = accept ? Cin  : cin_p0_q;
    sum_p0_d     = accept ? Sum  : sum_p0_q;
    cout_p0_d    = accept ? Cout : cout_p0_q;

    // stage p0 -> compare/count
    if (vld_p0_q) begin
      if (match) begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        if (fail_cnt_q == '0) first_fail_d = {a_p0_q, b_p0_q, cin_p0_q};
      end
    end

    case (state_q)
      CHECK: begin
        if (accept) idx_d = idx_q + 1'b1;
        if ((idx_q == IDX_END) && !vld_p0_q) state_d = DONE;
      end
      default: ;
    endcase

    if (start) begin
      state_d      = CHECK;
      idx_d        = '0;
      pass_cnt_d   = '0;
      fail_cnt_d   = '0;
      first_fail_d = '0;
      vld_p0_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      vld_p0_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      vld_p0_q     <= vld_p0_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p0_q    <= a_p0_d;
    b_p0_q    <= b_p0_d;
    cin_p0_q  <= cin_p0_d;
    sum_p0_q  <= sum_p0_d;
    cout_p0_q <= cout_p0_d;
  end

  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (fail_cnt_q == '0);

endmodule

// File: tb/tb_rca_result_checker.sv
// Scoreboard bench for rca_result_checker: each driven vector's expected outcome is queued,
// and the queue is drained into expected counts/first_fail when the run reports done.
module tb_rca_result_checker;

  localparam int W = 2;
  localparam int N = 9;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           vld = 1'b0;
  logic [W-1:0]   A = '0, B = '0, Sum = '0;
  logic           Cin = 1'b0, Cout = 1'b0;
  logic           ready, done, pass;
  logic [C-1:0]   pass_cnt, fail_cnt;
  logic [2*W:0]   first_fail;

  typedef struct {
    logic         match;
    logic [2*W:0] vec;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int failures = 0;

  rca_result_checker #(.WIDTH(W), .NUM_VECTORS(N), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .A(A), .B(B), .Cin(Cin), .Sum(Sum), .Cout(Cout),
    .ready(ready), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // err is XORed into the correct {Cout,Sum}; nonzero means a wrong DUT response.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W:0] err);
    logic [W:0] r;
    r = ({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c}) ^ err;
    A = a; B = b; Cin = c;
    {Cout, Sum} = r;
    vld = 1'b1;
    sb.push_back('{match: (err == '0), vec: {a, b, c}});
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    if (!done) check_eq("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic eval_run(input string tag);
    sb_t e;
    int ep, ef;
    logic [2*W:0] eff;
    ep = 0; ef = 0; eff = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.match) ep++;
      else begin
        if (ef == 0) eff = e.vec;
        ef++;
      end
    end
    check_eq({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(ep));
    check_eq({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(ef));
    check_eq({tag, "_first_fail"}, 32'(first_fail), 32'(eff));
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_pass"}, {31'd0, pass}, (ef == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check_eq({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
    check_eq({tag, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
    check_eq({tag, "_first_fail"}, 32'(first_fail), 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_pass"}, {31'd0, pass}, 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] ta, tb_;

    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    vld = 1'b1;
    tick();
    vld = 1'b0;
    check_eq("idle_ignores_vld", 32'(pass_cnt + fail_cnt), 32'd0);

    // Clean 3x3 sweep, vld also high on the start cycle (must be ignored).
    vld = 1'b1;
    pulse_start();
    check_eq("ready_after_start", {31'd0, ready}, 32'd1);
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        send(W'(a), W'(b), 1'b0, '0);
    wait_done();
    eval_run("sweep");

    // Injected error on A=2,B=1 (Sum=2'b10, Cout=0 instead of 3'b011).
    pulse_start();
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        send(W'(a), W'(b), 1'b0, (a == 2 && b == 1) ? 3'b001 : 3'b000);
    wait_done();
    check_eq("inject_ff_literal", 32'(first_fail), 32'b10_01_0);
    eval_run("inject");

    // Full-scale wrap: 3+3+1 = 7, Cout must carry the MSB.
    pulse_start();
    send(2'd3, 2'd3, 1'b1, 3'b000);
    send(2'd3, 2'd3, 1'b1, 3'b100);
    for (int i = 0; i < N - 2; i++)
      send(W'(i % 4), W'((i + 1) % 4), 1'(i % 2), '0);
    wait_done();
    check_eq("wrap_ff_literal", 32'(first_fail), 32'b11_11_1);
    eval_run("wrap");

    // Random gaps, then a 10th vld in the cycle after the 9th.
    pulse_start();
    for (int i = 0; i < N; i++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) tick();
      ta = W'($urandom_range(0, 3));
      tb_ = W'($urandom_range(0, 3));
      send(ta, tb_, 1'($urandom_range(0, 1)), '0);
    end
    check_eq("ready_low_after_9th", {31'd0, ready}, 32'd0);
    A = 2'd1; B = 2'd1; Cin = 1'b0; Sum = 2'd0; Cout = 1'b0;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check_eq("done_latency", 32'(n), 32'd2);
    eval_run("gapped");
    vld = 1'b1;
    tick();
    tick();
    vld = 1'b0;
    check_eq("done_ignores_vld", 32'(pass_cnt), 32'd9);

    // Restart from DONE with two errors; first_fail keeps the earlier one.
    pulse_start();
    check_eq("restart_clr_pass", 32'(pass_cnt), 32'd0);
    check_eq("restart_clr_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < N; i++)
      send(W'(i % 3), W'(i / 3), 1'(i % 2),
           (i == 2) ? 3'b010 : (i == 6) ? 3'b100 : 3'b000);
    wait_done();
    check_eq("restart_ff_literal", 32'(first_fail), 32'b10_00_0);
    eval_run("restart");

    // Reset mid-run after 4 vectors.
    pulse_start();
    for (int i = 0; i < 4; i++) send(W'(i % 3), 2'd1, 1'b0, '0);
    sb.delete();
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrun_reset");
    #10 rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_eq("post_reset_ready", {31'd0, ready}, 32'd0);
    check_eq("post_reset_done", {31'd0, done}, 32'd0);
    check_eq("post_reset_cnt", 32'(pass_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
